// File: rtl/pipe_core_pkg.sv
// pipe_core_pkg: opcode encodings, the NOP word, instruction field extraction
// and the small decode predicates shared by the core and its hazard unit.
package pipe_core_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_LOAD  = 4'd3;
  localparam logic [3:0] OP_STORE = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd15;

  // All-zero word decodes as NOP at any instruction width.
  localparam logic [63:0] NOP_INSTR = 64'd0;

  // Extract `width` bits starting at `lsb` from an instruction word.
  function automatic logic [31:0] get_field(input logic [63:0] ins, input int lsb,
                                            input int width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return 32'((ins >> lsb) & mask);
  endfunction

  // Opcodes outside this set are executed as NOP.
  function automatic logic op_legal(input logic [3:0] op);
    return op inside {OP_NOP, OP_ADD, OP_SUB, OP_LOAD, OP_STORE, OP_HALT};
  endfunction

  // Ops that produce a register result.
  function automatic logic op_writes_reg(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_LOAD};
  endfunction

  // Ops that consume the s1 field as a register.
  function automatic logic op_reads_s1(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_STORE};
  endfunction

  // Ops that consume the s2 field as a register (STORE/LOAD use it as imm).
  function automatic logic op_reads_s2(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB};
  endfunction

endpackage

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: compares the ID-stage sources against the EX-stage
// destination. Build option PIPE_FORWARDING_EN turns matches into EX operand
// forward selects; without it a match stalls ID for one cycle.
module pipe_hazard_unit
  import pipe_core_pkg::*;
#(
  parameter int RA = 4
) (
  input  logic [3:0]    id_op,
  input  logic [RA-1:0] id_s1,
  input  logic [RA-1:0] id_s2,
  input  logic [3:0]    ex_op,
  input  logic [RA-1:0] ex_dest,
  output logic          stall,
  output logic          fwd_a,
  output logic          fwd_b
);

  logic ex_prod;
  logic raw_a;
  logic raw_b;

  // R0 is never a producer, so writes to it cannot create a dependency.
  assign ex_prod = op_writes_reg(ex_op) && (ex_dest != '0);
  assign raw_a   = ex_prod && op_reads_s1(id_op) && (id_s1 == ex_dest);
  assign raw_b   = ex_prod && op_reads_s2(id_op) && (id_s2 == ex_dest);

`ifdef PIPE_FORWARDING_EN
  assign stall = 1'b0;
  assign fwd_a = raw_a;
  assign fwd_b = raw_b;
`else
  assign stall = raw_a | raw_b;
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

endmodule

// File: rtl/pipe_core_param.sv
// pipe_core_param: 4-stage in-order core (IF, ID, EX, WB) with a host
// programming port and a retire trace. Build option PIPE_FORWARDING_EN
// (see pipe_hazard_unit) trades the RAW stall for EX/WB -> EX forwarding.
module pipe_core_param
  import pipe_core_pkg::*;
#(
  parameter int  DW         = 8,
  parameter int  NREGS      = 16,
  parameter int  IMEM_DEPTH = 16,
  parameter int  DMEM_DEPTH = 16,
  localparam int RA         = $clog2(NREGS),
  localparam int PA         = $clog2(IMEM_DEPTH),
  localparam int IW         = 4 + 3*RA,
  localparam int PW         = (IW > DW) ? IW : DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic          prog_sel,
  input  logic [PA-1:0] prog_addr,
  input  logic [PW-1:0] prog_wdata,
  input  logic [RA-1:0] dbg_raddr,
  output logic [DW-1:0] dbg_rdata,
  output logic [PA-1:0] pc,
  output logic          halted,
  output logic          stall,
  output logic          retire_valid,
  output logic [3:0]    retire_op,
  output logic [RA-1:0] retire_dest,
  output logic [DW-1:0] retire_data,
  output logic [15:0]   retire_count
);

  localparam int DA = $clog2(DMEM_DEPTH);

  typedef struct packed {
    logic [3:0]    op;
    logic [RA-1:0] dest;   // zero unless op writes a register
    logic [RA-1:0] imm;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          fwd_a;
    logic          fwd_b;
  } id_ex_t;

  typedef struct packed {
    logic [3:0]    op;
    logic [RA-1:0] dest;
    logic [DW-1:0] data;
    logic          wen;    // real register write (dest != 0)
  } ex_wb_t;

  logic [IW-1:0] imem [IMEM_DEPTH];
  logic [DW-1:0] dmem [DMEM_DEPTH];
  logic [DW-1:0] rf   [NREGS];

  logic [IW-1:0] if_id;
  id_ex_t        id_ex, id_ex_d;
  ex_wb_t        ex_wb, ex_wb_d;

  logic [3:0]    id_op_raw, id_op;
  logic [RA-1:0] id_dest, id_s1, id_s2;
  logic [DW-1:0] id_a, id_b;
  logic          hz_stall, hz_fwd_a, hz_fwd_b;

  logic [DW-1:0] ex_a, ex_b, ex_res;
  logic [DA-1:0] ex_addr;
  logic          ex_halt;
  logic          prog_en;

  // Host writes only land while the core is not executing.
  assign prog_en = prog_we && (reset || halted);

  // ID: decode fields, read sources with write-before-read bypass from WB.
  always_comb begin
    id_op_raw = 4'(get_field(64'(if_id), 3*RA, 4));
    id_op     = op_legal(id_op_raw) ? id_op_raw : OP_NOP;
    id_dest   = RA'(get_field(64'(if_id), 2*RA, RA));
    id_s1     = RA'(get_field(64'(if_id), RA, RA));
    id_s2     = RA'(get_field(64'(if_id), 0, RA));
    id_a      = rf[id_s1];
    id_b      = rf[id_s2];
    if (ex_wb.wen && (ex_wb.dest == id_s1)) id_a = ex_wb.data;
    if (ex_wb.wen && (ex_wb.dest == id_s2)) id_b = ex_wb.data;
    id_ex_d.op    = id_op;
    id_ex_d.dest  = op_writes_reg(id_op) ? id_dest : '0;
    id_ex_d.imm   = id_s2;
    id_ex_d.a     = id_a;
    id_ex_d.b     = id_b;
    id_ex_d.fwd_a = hz_fwd_a;
    id_ex_d.fwd_b = hz_fwd_b;
  end

  pipe_hazard_unit #(.RA(RA)) u_hazard (
    .id_op   (id_op),
    .id_s1   (id_s1),
    .id_s2   (id_s2),
    .ex_op   (id_ex.op),
    .ex_dest (id_ex.dest),
    .stall   (hz_stall),
    .fwd_a   (hz_fwd_a),
    .fwd_b   (hz_fwd_b)
  );

  assign stall = hz_stall && !reset;

  // EX: operand forwarding mux, ALU and asynchronous dmem read.
  always_comb begin
    ex_a    = id_ex.fwd_a ? ex_wb.data : id_ex.a;
    ex_b    = id_ex.fwd_b ? ex_wb.data : id_ex.b;
    ex_addr = id_ex.imm[DA-1:0];
    ex_halt = (id_ex.op == OP_HALT);
    case (id_ex.op)
      OP_ADD:   ex_res = ex_a + ex_b;
      OP_SUB:   ex_res = ex_a - ex_b;
      OP_LOAD:  ex_res = dmem[ex_addr];
      OP_STORE: ex_res = ex_a;
      default:  ex_res = '0;
    endcase
    ex_wb_d.op   = id_ex.op;
    ex_wb_d.dest = id_ex.dest;
    ex_wb_d.data = ex_res;
    ex_wb_d.wen  = op_writes_reg(id_ex.op) && (id_ex.dest != '0);
  end

  // IF: fetch into IF/ID; frozen by HALT, held by a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= '0;
      if_id <= IW'(NOP_INSTR);
    end else if (halted || ex_halt) begin
      if_id <= IW'(NOP_INSTR);
    end else if (!hz_stall) begin
      if_id <= imem[pc];
      pc    <= pc + PA'(1);
    end
  end

  // ID/EX register: bubble on stall, HALT flush or while halted.
  always_ff @(posedge clk) begin
    if (reset || halted || ex_halt || hz_stall) id_ex <= '0;
    else                                        id_ex <= id_ex_d;
  end

  // EX/WB register keeps draining so the HALT itself retires exactly once.
  always_ff @(posedge clk) begin
    if (reset) ex_wb <= '0;
    else       ex_wb <= ex_wb_d;
  end

  // Halt latch and saturating retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      halted       <= 1'b0;
      retire_count <= '0;
    end else begin
      if (ex_halt) halted <= 1'b1;
      if (retire_valid && (retire_count != 16'hFFFF))
        retire_count <= retire_count + 16'd1;
    end
  end

  // WB: register file write; R0 is never written so it always reads 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (ex_wb.wen) begin
      rf[ex_wb.dest] <= ex_wb.data;
    end
  end

  // Instruction memory: host writes only.
  always_ff @(posedge clk) begin
    if (prog_en && !prog_sel) imem[prog_addr] <= prog_wdata[IW-1:0];
  end

  // Data memory: host writes, or STORE at the end of EX.
  always_ff @(posedge clk) begin
    if (prog_en && prog_sel)
      dmem[prog_addr[DA-1:0]] <= prog_wdata[DW-1:0];
    else if (!reset && (id_ex.op == OP_STORE))
      dmem[ex_addr] <= ex_a;
  end

  assign dbg_rdata    = rf[dbg_raddr];
  assign retire_valid = (ex_wb.op != OP_NOP);
  assign retire_op    = ex_wb.op;
  assign retire_dest  = ex_wb.dest;
  assign retire_data  = ex_wb.data;

endmodule

// File: tb/tb_pipe_core_param.sv
// tb_pipe_core_param: programs the core through the host port, runs small
// programs to HALT and scores every retire against an expected queue.
module tb_pipe_core_param;

  localparam int DW = 8;
  localparam int RA = 4;
  localparam int PA = 4;
  localparam int PW = 16;

`ifdef PIPE_FORWARDING_EN
  localparam int HZ = 0;
`else
  localparam int HZ = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          prog_we = 1'b0;
  logic          prog_sel = 1'b0;
  logic [PA-1:0] prog_addr = '0;
  logic [PW-1:0] prog_wdata = '0;
  logic [RA-1:0] dbg_raddr = '0;
  logic [DW-1:0] dbg_rdata;
  logic [PA-1:0] pc;
  logic          halted, stall, retire_valid;
  logic [3:0]    retire_op;
  logic [RA-1:0] retire_dest;
  logic [DW-1:0] retire_data;
  logic [15:0]   retire_count;

  typedef struct packed {
    logic [3:0]    op;
    logic [RA-1:0] dest;
    logic [DW-1:0] data;
  } ret_t;

  ret_t        exp_q[$];
  logic [15:0] pbuf[$];
  int          checks = 0;
  int          failures = 0;

  pipe_core_param dut (
    .clk          (clk),
    .reset        (reset),
    .prog_we      (prog_we),
    .prog_sel     (prog_sel),
    .prog_addr    (prog_addr),
    .prog_wdata   (prog_wdata),
    .dbg_raddr    (dbg_raddr),
    .dbg_rdata    (dbg_rdata),
    .pc           (pc),
    .halted       (halted),
    .stall        (stall),
    .retire_valid (retire_valid),
    .retire_op    (retire_op),
    .retire_dest  (retire_dest),
    .retire_data  (retire_data),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Scoreboard: every retire must match the next expected entry.
  always @(negedge clk) begin
    ret_t e;
    if (retire_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL retire_unexpected got op=%0d dest=%0d data=%0d", retire_op, retire_dest, retire_data);
      end else begin
        e = exp_q.pop_front();
        if ({retire_op, retire_dest, retire_data} !== e) begin
          failures++;
          $display("FAIL retire got op=%0d dest=%0d data=%0d exp op=%0d dest=%0d data=%0d",
                   retire_op, retire_dest, retire_data, e.op, e.dest, e.data);
        end
      end
    end
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] d,
                                      input logic [3:0] s1, input logic [3:0] s2);
    return {op, d, s1, s2};
  endfunction

  function automatic void expect_ret(input logic [3:0] op, input logic [3:0] d, input logic [7:0] v);
    exp_q.push_back({op, d, v});
  endfunction

  task automatic prog(input logic sel, input logic [PA-1:0] a, input logic [PW-1:0] d);
    prog_we = 1'b1; prog_sel = sel; prog_addr = a; prog_wdata = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic enter_reset();
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Reset, preset M[0]=10 and M[1]=5, then write pbuf into imem from 0.
  task automatic setup_prog();
    enter_reset();
    prog(1'b1, 4'd0, 16'd10);
    prog(1'b1, 4'd1, 16'd5);
    for (int i = 0; i < pbuf.size(); i++) prog(1'b0, PA'(i), pbuf[i]);
  endtask

  task automatic rd(input logic [RA-1:0] r, output logic [DW-1:0] v);
    dbg_raddr = r;
    #1;
    v = dbg_rdata;
  endtask

  // Release reset and clock until halted; optionally hammer the host port.
  task automatic run_to_halt(input bit poke, output int stalls, output bit done);
    stalls = 0;
    done   = 1'b0;
    reset  = 1'b0;
    if (poke) begin
      prog_we = 1'b1; prog_sel = 1'b1; prog_addr = 4'd9; prog_wdata = 16'h00AA;
    end
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (halted) begin
        done = 1'b1;
        prog_we = 1'b0;
      end
    end
    prog_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) prog(1'b0, PA'(i), 16'h0000);
    checks++; if (pc !== 4'd0) begin failures++; $display("FAIL rst_pc got=%0d exp=0", pc); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%0b exp=0", halted); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", stall); end
    checks++; if (retire_valid !== 1'b0) begin failures++; $display("FAIL rst_retire_valid got=%0b exp=0", retire_valid); end
    checks++; if (retire_count !== 16'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", retire_count); end
    rd(4'd1, v);
    checks++; if (v !== 8'd0) begin failures++; $display("FAIL rst_r1 got=%0d exp=0", v); end
  endtask

  task automatic test_load_add();
    int st; bit ok; logic [DW-1:0] v;
    pbuf = '{enc(3,2,0,0), enc(3,3,0,1), enc(1,1,2,3), enc(15,0,0,0)};
    setup_prog();
    expect_ret(3,2,10); expect_ret(3,3,5); expect_ret(1,1,15); expect_ret(15,0,0);
    run_to_halt(1'b0, st, ok);
    checks++; if (!ok) begin failures++; $display("FAIL la_timeout halted=%0b exp=1", halted); end
    checks++; if (st != HZ) begin failures++; $display("FAIL la_stalls got=%0d exp=%0d", st, HZ); end
    @(negedge clk);
    rd(4'd1, v);
    checks++; if (v !== 8'd15) begin failures++; $display("FAIL la_r1 got=%0d exp=15", v); end
    checks++; if (retire_count !== 16'd4) begin failures++; $display("FAIL la_count got=%0d exp=4", retire_count); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL la_pending got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_raw();
    int st; bit ok; logic [DW-1:0] v;
    pbuf = '{enc(3,2,0,0), enc(3,3,0,1), enc(0,0,0,0), enc(1,1,2,3), enc(2,4,1,2), enc(15,0,0,0)};
    setup_prog();
    expect_ret(3,2,10); expect_ret(3,3,5); expect_ret(1,1,15); expect_ret(2,4,5); expect_ret(15,0,0);
    run_to_halt(1'b0, st, ok);
    checks++; if (!ok) begin failures++; $display("FAIL raw_timeout halted=%0b exp=1", halted); end
    checks++; if (st != HZ) begin failures++; $display("FAIL raw_stalls got=%0d exp=%0d", st, HZ); end
    @(negedge clk);
    rd(4'd4, v);
    checks++; if (v !== 8'd5) begin failures++; $display("FAIL raw_r4 got=%0d exp=5", v); end
    checks++; if (retire_count !== 16'd5) begin failures++; $display("FAIL raw_count got=%0d exp=5", retire_count); end
  endtask

  task automatic test_r0();
    int st; bit ok; logic [DW-1:0] v;
    pbuf = '{enc(3,2,0,0), enc(3,3,0,1), enc(0,0,0,0), enc(0,0,0,0),
             enc(1,0,2,3), enc(1,6,0,2), enc(15,0,0,0)};
    setup_prog();
    expect_ret(3,2,10); expect_ret(3,3,5); expect_ret(1,0,15); expect_ret(1,6,10); expect_ret(15,0,0);
    run_to_halt(1'b0, st, ok);
    checks++; if (!ok) begin failures++; $display("FAIL r0_timeout halted=%0b exp=1", halted); end
    checks++; if (st != 0) begin failures++; $display("FAIL r0_stalls got=%0d exp=0", st); end
    @(negedge clk);
    rd(4'd6, v);
    checks++; if (v !== 8'd10) begin failures++; $display("FAIL r0_r6 got=%0d exp=10", v); end
    rd(4'd0, v);
    checks++; if (v !== 8'd0) begin failures++; $display("FAIL r0_r0 got=%0d exp=0", v); end
  endtask

  task automatic test_store_load();
    int st; bit ok; logic [DW-1:0] v;
    pbuf = '{enc(3,2,0,0), enc(3,3,0,1), enc(0,0,0,0), enc(1,1,2,3),
             enc(4,0,1,9), enc(3,7,0,9), enc(15,0,0,0)};
    setup_prog();
    expect_ret(3,2,10); expect_ret(3,3,5); expect_ret(1,1,15);
    expect_ret(4,0,15); expect_ret(3,7,15); expect_ret(15,0,0);
    run_to_halt(1'b1, st, ok);
    checks++; if (!ok) begin failures++; $display("FAIL st_timeout halted=%0b exp=1", halted); end
    checks++; if (st != HZ) begin failures++; $display("FAIL st_stalls got=%0d exp=%0d", st, HZ); end
    @(negedge clk);
    rd(4'd7, v);
    checks++; if (v !== 8'd15) begin failures++; $display("FAIL st_r7 got=%0d exp=15", v); end
    // M[9] must still hold the stored value after a reset and the ignored host writes.
    pbuf = '{enc(3,5,0,9), enc(15,0,0,0)};
    setup_prog();
    expect_ret(3,5,15); expect_ret(15,0,0);
    run_to_halt(1'b0, st, ok);
    checks++; if (!ok) begin failures++; $display("FAIL st2_timeout halted=%0b exp=1", halted); end
    @(negedge clk);
    rd(4'd5, v);
    checks++; if (v !== 8'd15) begin failures++; $display("FAIL st2_m9 got=%0d exp=15", v); end
  endtask

  task automatic test_halt();
    int st; bit ok; logic [DW-1:0] v;
    pbuf = '{enc(3,2,0,0), enc(15,0,0,0), enc(1,8,2,2)};
    setup_prog();
    expect_ret(3,2,10); expect_ret(15,0,0);
    run_to_halt(1'b0, st, ok);
    checks++; if (!ok) begin failures++; $display("FAIL halt_timeout halted=%0b exp=1", halted); end
    checks++; if (pc !== 4'd3) begin failures++; $display("FAIL halt_pc got=%0d exp=3", pc); end
    repeat (4) @(negedge clk);
    checks++; if (pc !== 4'd3) begin failures++; $display("FAIL halt_pc_frozen got=%0d exp=3", pc); end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_sticky got=%0b exp=1", halted); end
    checks++; if (retire_valid !== 1'b0) begin failures++; $display("FAIL halt_retire got=%0b exp=0", retire_valid); end
    checks++; if (retire_count !== 16'd2) begin failures++; $display("FAIL halt_count got=%0d exp=2", retire_count); end
    rd(4'd8, v);
    checks++; if (v !== 8'd0) begin failures++; $display("FAIL halt_r8 got=%0d exp=0", v); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL halt_pending got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] v;
    pbuf = '{enc(3,2,0,0), enc(3,3,0,1), enc(0,0,0,0), enc(0,0,0,0), enc(1,1,2,3), enc(15,0,0,0)};
    setup_prog();
    expect_ret(3,2,10); expect_ret(3,3,5); expect_ret(1,1,15);
    reset = 1'b0;
    repeat (7) @(negedge clk);
    checks++; if ({retire_valid, retire_op} !== 5'b1_0001) begin
      failures++; $display("FAIL mid_add_in_wb got=%0b/%0d exp=1/1", retire_valid, retire_op); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (pc !== 4'd0) begin failures++; $display("FAIL mid_pc got=%0d exp=0", pc); end
    checks++; if (retire_valid !== 1'b0) begin failures++; $display("FAIL mid_retire got=%0b exp=0", retire_valid); end
    checks++; if (retire_count !== 16'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", retire_count); end
    rd(4'd1, v);
    checks++; if (v !== 8'd0) begin failures++; $display("FAIL mid_r1 got=%0d exp=0", v); end
    rd(4'd2, v);
    checks++; if (v !== 8'd0) begin failures++; $display("FAIL mid_r2 got=%0d exp=0", v); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL mid_pending got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_raw();
    test_r0();
    test_store_load();
    test_halt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
